// File: rtl/axioma_int_sequencer_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer: vector numbers, FSM encoding, defaults.
// The vector numbers are common with the vectored interrupt controller.
package axioma_int_sequencer_pkg;

    localparam int PC_WIDTH_DEF      = 14;
    localparam int VECTOR_STRIDE_DEF = 2;
    localparam int VECTOR_WIDTH      = 6;

    localparam logic [VECTOR_WIDTH-1:0] VEC_RESET    = 6'h00;
    localparam logic [VECTOR_WIDTH-1:0] VEC_INT0     = 6'h01;
    localparam logic [VECTOR_WIDTH-1:0] VEC_INT1     = 6'h02;
    localparam logic [VECTOR_WIDTH-1:0] VEC_TIMER0   = 6'h0E;
    localparam logic [VECTOR_WIDTH-1:0] VEC_UART_RX  = 6'h12;
    localparam logic [VECTOR_WIDTH-1:0] VEC_UART_TX  = 6'h14;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_LO = 3'd1,
        ST_PUSH_HI = 3'd2,
        ST_JUMP    = 3'd3,
        ST_POP_HI  = 3'd4,
        ST_POP_LO  = 3'd5,
        ST_RET     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/axioma_int_sequencer.sv
// Interrupt entry/exit sequencer: pushes the return PC and jumps to the vector on entry,
// pops the PC and restores I on RETI. Owns the data-memory stack port while busy.
module axioma_int_sequencer
    import axioma_int_sequencer_pkg::*;
#(
    parameter int PC_WIDTH      = PC_WIDTH_DEF,
    parameter int VECTOR_STRIDE = VECTOR_STRIDE_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    int_request_i,
    input  logic [VECTOR_WIDTH-1:0] int_vector_i,
    output logic                    int_ack_o,
    output logic                    reti_done_o,
    input  logic                    instr_boundary_i,
    input  logic                    reti_i,
    input  logic                    i_flag_i,
    output logic                    i_flag_clr_o,
    output logic                    i_flag_set_o,
    input  logic [PC_WIDTH-1:0]     pc_i,
    output logic                    pc_load_o,
    output logic [PC_WIDTH-1:0]     pc_o,
    input  logic [15:0]             sp_i,
    output logic                    sp_wr_o,
    output logic [15:0]             sp_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [15:0]             mem_addr_o,
    output logic [7:0]              mem_wdata_o,
    input  logic [7:0]              mem_rdata_i,
    input  logic                    mem_ready_i,
    output logic                    cpu_stall_o,
    output logic                    busy_o
);

    seq_state_t              state, state_nx;
    logic [PC_WIDTH-1:0]     pc_q;
    logic [VECTOR_WIDTH-1:0] vec_q;
    logic [15:0]             sp_q;
    logic [15:0]             pop_q;
    logic                    block_next;
    logic                    take_irq;

    // block_next lets exactly one instruction run after RETI before another entry.
    assign take_irq = int_request_i & i_flag_i & ~block_next;

    // NOTE: the latch bank is a few flops, not a RAM, so it is cleared on reset like the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pc_q       <= '0;
            vec_q      <= '0;
            sp_q       <= '0;
            pop_q      <= '0;
            block_next <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state <= state_nx;
            if (state == ST_IDLE && instr_boundary_i) begin
                if (reti_i) begin
                    sp_q <= sp_i;
                end else if (take_irq) begin
                    pc_q  <= pc_i;
                    vec_q <= int_vector_i;
                    sp_q  <= sp_i;
                end else if (block_next) begin
                    block_next <= 1'b0;
                end
            end
            if (state == ST_POP_HI && mem_ready_i) pop_q[15:8] <= mem_rdata_i;
            if (state == ST_POP_LO && mem_ready_i) pop_q[7:0]  <= mem_rdata_i;
            if (state == ST_RET)                   block_next  <= 1'b1;
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        int_ack_o    = 1'b0;
        reti_done_o  = 1'b0;
        i_flag_clr_o = 1'b0;
        i_flag_set_o = 1'b0;
        pc_load_o    = 1'b0;
        pc_o         = '0;
        sp_wr_o      = 1'b0;
        sp_o         = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        cpu_stall_o  = (state != ST_IDLE);
        busy_o       = (state != ST_IDLE);

        unique case (state)
            ST_IDLE: begin
                if (instr_boundary_i) begin
                    if (reti_i)        state_nx = ST_POP_HI;
                    else if (take_irq) state_nx = ST_PUSH_LO;
                end
            end
            ST_PUSH_LO: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = sp_q;
                mem_wdata_o = pc_q[7:0];
                if (mem_ready_i) state_nx = ST_PUSH_HI;
            end
            ST_PUSH_HI: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = sp_q - 16'd1;
                mem_wdata_o = 8'(16'(pc_q) >> 8);
                if (mem_ready_i) state_nx = ST_JUMP;
            end
            ST_JUMP: begin
                pc_load_o    = 1'b1;
                pc_o         = PC_WIDTH'(32'(vec_q) * VECTOR_STRIDE);
                int_ack_o    = 1'b1;
                i_flag_clr_o = 1'b1;
                sp_wr_o      = 1'b1;
                sp_o         = sp_q - 16'd2;
                state_nx     = ST_IDLE;
            end
            ST_POP_HI: begin
                mem_req_o  = 1'b1;
                mem_addr_o = sp_q + 16'd1;
                if (mem_ready_i) state_nx = ST_POP_LO;
            end
            ST_POP_LO: begin
                mem_req_o  = 1'b1;
                mem_addr_o = sp_q + 16'd2;
                if (mem_ready_i) state_nx = ST_RET;
            end
            ST_RET: begin
                pc_load_o    = 1'b1;
                pc_o         = PC_WIDTH'(pop_q);
                sp_wr_o      = 1'b1;
                sp_o         = sp_q + 16'd2;
                i_flag_set_o = 1'b1;
                reti_done_o  = 1'b1;
                state_nx     = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axioma_int_sequencer.sv
// Directed bench for axioma_int_sequencer: entry, RETI, RETI/IRQ priority, wait states,
// blocked requests, SP wrap and asynchronous reset mid-sequence.
module tb_axioma_int_sequencer;

    localparam int PC_WIDTH = 14;

    // control bundle order: ack, done, clr, set, pc_load, sp_wr, req, we, stall, busy
    localparam logic [9:0] C_IDLE = 10'b0000000000;
    localparam logic [9:0] C_PUSH = 10'b0000001111;
    localparam logic [9:0] C_JUMP = 10'b1010110011;
    localparam logic [9:0] C_POP  = 10'b0000001011;
    localparam logic [9:0] C_RET  = 10'b0101110011;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                int_request_i;
    logic [5:0]          int_vector_i;
    logic                int_ack_o;
    logic                reti_done_o;
    logic                instr_boundary_i;
    logic                reti_i;
    logic                i_flag_i;
    logic                i_flag_clr_o;
    logic                i_flag_set_o;
    logic [PC_WIDTH-1:0] pc_i;
    logic                pc_load_o;
    logic [PC_WIDTH-1:0] pc_o;
    logic [15:0]         sp_i;
    logic                sp_wr_o;
    logic [15:0]         sp_o;
    logic                mem_req_o;
    logic                mem_we_o;
    logic [15:0]         mem_addr_o;
    logic [7:0]          mem_wdata_o;
    logic [7:0]          mem_rdata_i;
    logic                mem_ready_i;
    logic                cpu_stall_o;
    logic                busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:65535];

    axioma_int_sequencer #(.PC_WIDTH(PC_WIDTH), .VECTOR_STRIDE(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .int_request_i    (int_request_i),
        .int_vector_i     (int_vector_i),
        .int_ack_o        (int_ack_o),
        .reti_done_o      (reti_done_o),
        .instr_boundary_i (instr_boundary_i),
        .reti_i           (reti_i),
        .i_flag_i         (i_flag_i),
        .i_flag_clr_o     (i_flag_clr_o),
        .i_flag_set_o     (i_flag_set_o),
        .pc_i             (pc_i),
        .pc_load_o        (pc_load_o),
        .pc_o             (pc_o),
        .sp_i             (sp_i),
        .sp_wr_o          (sp_wr_o),
        .sp_o             (sp_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i),
        .mem_ready_i      (mem_ready_i),
        .cpu_stall_o      (cpu_stall_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_o && mem_we_o && mem_ready_i) mem[mem_addr_o] <= mem_wdata_o;
    end

    assign mem_rdata_i = (mem_req_o && !mem_we_o) ? mem[mem_addr_o] : 8'h00;

    function automatic logic [9:0] ctrl();
        return {int_ack_o, reti_done_o, i_flag_clr_o, i_flag_set_o, pc_load_o,
                sp_wr_o, mem_req_o, mem_we_o, cpu_stall_o, busy_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one boundary carrying an interrupt request, then the core stalls
    task automatic boundary_irq(input logic [PC_WIDTH-1:0] pc, input logic [5:0] vec,
                                input logic [15:0] sp);
        pc_i             = pc;
        int_vector_i     = vec;
        sp_i             = sp;
        i_flag_i         = 1'b1;
        int_request_i    = 1'b1;
        instr_boundary_i = 1'b1;
        tick();
        int_request_i    = 1'b0;
        instr_boundary_i = 1'b0;
    endtask

    task automatic boundary_reti(input logic [15:0] sp);
        sp_i             = sp;
        reti_i           = 1'b1;
        instr_boundary_i = 1'b1;
        tick();
        reti_i           = 1'b0;
        instr_boundary_i = 1'b0;
    endtask

    initial begin
        reset_n          = 1'b0;
        int_request_i    = 1'b0;
        int_vector_i     = '0;
        instr_boundary_i = 1'b0;
        reti_i           = 1'b0;
        i_flag_i         = 1'b0;
        pc_i             = '0;
        sp_i             = '0;
        mem_ready_i      = 1'b1;
        #12;
        check("reset_ctrl", 32'(ctrl()), 32'(C_IDLE));
        check("reset_pc_sp", {pc_o, sp_o}, 32'h0);
        check("reset_mem_bus", {mem_addr_o, mem_wdata_o}, 32'h0);
        reset_n = 1'b1;
        tick();

        // 1: entry, vector 0x0E
        boundary_irq(14'h1234, 6'h0E, 16'h08FF);
        check("t1_pushlo_ctrl", 32'(ctrl()), 32'(C_PUSH));
        check("t1_pushlo_bus", {mem_addr_o, mem_wdata_o}, {16'h08FF, 8'h34});
        tick();
        check("t1_pushhi_ctrl", 32'(ctrl()), 32'(C_PUSH));
        check("t1_pushhi_bus", {mem_addr_o, mem_wdata_o}, {16'h08FE, 8'h12});
        tick();
        check("t1_jump_ctrl", 32'(ctrl()), 32'(C_JUMP));
        check("t1_jump_pc", 32'(pc_o), 32'h001C);
        check("t1_jump_sp", 32'(sp_o), 32'h08FD);
        tick();
        check("t1_idle_ctrl", 32'(ctrl()), 32'(C_IDLE));
        check("t1_stack", {mem[16'h08FF], mem[16'h08FE]}, 32'h3412);

        // 2: RETI pops what entry pushed
        boundary_reti(16'h08FD);
        check("t2_pophi_ctrl", 32'(ctrl()), 32'(C_POP));
        check("t2_pophi_addr", 32'(mem_addr_o), 32'h08FE);
        tick();
        check("t2_poplo_addr", 32'(mem_addr_o), 32'h08FF);
        tick();
        check("t2_ret_ctrl", 32'(ctrl()), 32'(C_RET));
        check("t2_ret_pc", 32'(pc_o), 32'h1234);
        check("t2_ret_sp", 32'(sp_o), 32'h08FF);
        tick();
        check("t2_idle_ctrl", 32'(ctrl()), 32'(C_IDLE));
        instr_boundary_i = 1'b1;   // one instruction after RETI
        tick();
        instr_boundary_i = 1'b0;

        // 3: RETI wins over a simultaneous request, then one boundary is skipped
        pc_i          = 14'h0100;
        int_vector_i  = 6'h03;
        i_flag_i      = 1'b1;
        int_request_i = 1'b1;
        boundary_reti(16'h08FD);
        int_request_i = 1'b1;
        check("t3_pop_first", 32'(ctrl()), 32'(C_POP));
        tick();
        tick();
        check("t3_ret_ctrl", 32'(ctrl()), 32'(C_RET));
        tick();
        sp_i             = 16'h0200;
        instr_boundary_i = 1'b1;
        tick();
        check("t3_blocked", 32'(ctrl()), 32'(C_IDLE));
        tick();
        instr_boundary_i = 1'b0;
        int_request_i    = 1'b0;
        check("t3_taken_ctrl", 32'(ctrl()), 32'(C_PUSH));
        check("t3_taken_addr", 32'(mem_addr_o), 32'h0200);
        tick();
        tick();
        check("t3_jump_pc_sp", {pc_o, sp_o}, {14'h0006, 16'h01FE});
        tick();

        // 4: three wait states in PUSH_HI stretch entry to 6 cycles
        boundary_irq(14'h3FFF, 6'h3F, 16'h1000);
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t4_wait_ctrl", 32'(ctrl()), 32'(C_PUSH));
            check("t4_wait_bus", {mem_addr_o, mem_wdata_o}, {16'h0FFF, 8'h3F});
            tick();
        end
        mem_ready_i = 1'b1;
        tick();
        check("t4_jump_ctrl", 32'(ctrl()), 32'(C_JUMP));
        check("t4_jump_pc", 32'(pc_o), 32'h007E);
        check("t4_stack", {mem[16'h1000], mem[16'h0FFF]}, 32'hFF3F);
        tick();

        // 5: request ignored with I=0 or off-boundary; SP wrap
        i_flag_i         = 1'b0;
        int_request_i    = 1'b1;
        instr_boundary_i = 1'b1;
        tick();
        check("t5_i0", 32'(ctrl()), 32'(C_IDLE));
        i_flag_i         = 1'b1;
        instr_boundary_i = 1'b0;
        tick();
        check("t5_noboundary", 32'(ctrl()), 32'(C_IDLE));
        int_request_i = 1'b0;
        boundary_irq(14'h0ABC, 6'h01, 16'h0001);
        tick();
        tick();
        check("t5_wrap1_sp", 32'(sp_o), 32'hFFFF);
        check("t5_wrap1_stack", {mem[16'h0001], mem[16'h0000]}, 32'hBC0A);
        tick();
        boundary_irq(14'h2A55, 6'h20, 16'h0000);
        tick();
        check("t5_wrap0_hiaddr", 32'(mem_addr_o), 32'hFFFF);
        tick();
        check("t5_wrap0_pc_sp", {pc_o, sp_o}, {14'h0040, 16'hFFFE});
        tick();

        // 6: asynchronous reset during POP_LO, then a normal entry
        boundary_reti(16'hFFFE);
        tick();
        check("t6_poplo_addr", 32'(mem_addr_o), 32'h0000);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_ctrl", 32'(ctrl()), 32'(C_IDLE));
        check("t6_async_bus", {pc_o, sp_o}, 32'h0);
        #3 reset_n = 1'b1;
        tick();
        boundary_irq(14'h1234, 6'h0E, 16'h08FF);
        check("t6_fresh_push", 32'(ctrl()), 32'(C_PUSH));
        tick();
        tick();
        check("t6_fresh_jump", 32'(ctrl()), 32'(C_JUMP));
        check("t6_fresh_pc_sp", {pc_o, sp_o}, {14'h001C, 16'h08FD});
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
